// File: rtl/fetch_sequencer.sv
// ---------------------------------------------------------------------------
// fetch_sequencer
//   Drives the per-core PC register (load enable and next value), issues
//   instruction-fetch reads at the current PC and waits for the icache hit.
//   It buffers one redirect that arrives while fetch cannot advance, and it
//   stops fetch permanently on halt. Only reset leaves the halted state.
//
//   Optional feature macro: FETCH_PERF_EN
//     When defined, the outputs fetch_count and redir_count are added.
//     fetch_count counts PC loads. redir_count counts PC loads whose value
//     came from a redirect, either live or buffered. Both counters hold
//     their value while halted.
//
// Parameters
//   PC_INIT        reset/restart PC (word aligned), driven on pc_next in reset
//   PC_STEP        sequential PC increment in bytes
// Ports
//   CLK            clock, all state on rising edge
//   nRST           synchronous active-low reset
//   pc_cur         current PC from the PC register
//   ihit           icache returned data for iaddr this cycle
//   stall          downstream cannot accept an instruction
//   branch_take    resolved taken branch (older instruction)
//   branch_target  branch destination
//   jump_take      jump/jr redirect (younger instruction)
//   jump_target    jump destination
//   halt           halt instruction reached commit
//   pc_EN          PC register load enable
//   pc_next        PC register next value
//   iREN           instruction read enable
//   iaddr          instruction read address (= pc_cur)
//   redir_pending  a redirect is buffered and not yet applied
//   halted         fetch stopped
//   fetch_count    (FETCH_PERF_EN) number of PC loads
//   redir_count    (FETCH_PERF_EN) number of PC loads from a redirect
// ---------------------------------------------------------------------------
module fetch_sequencer #(
  parameter logic [31:0] PC_INIT = 32'h0000_0000,
  parameter logic [31:0] PC_STEP = 32'd4
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic [31:0] pc_cur,
  input  logic        ihit,
  input  logic        stall,
  input  logic        branch_take,
  input  logic [31:0] branch_target,
  input  logic        jump_take,
  input  logic [31:0] jump_target,
  input  logic        halt,
  output logic        pc_EN,
  output logic [31:0] pc_next,
  output logic        iREN,
  output logic [31:0] iaddr,
  output logic        redir_pending,
  output logic        halted
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] fetch_count,
  output logic [31:0] redir_count
`endif
);

  typedef enum logic [0:0] {S_FETCH = 1'b0, S_HALT = 1'b1} state_t;

  state_t      state_q, state_d;
  logic        buf_valid_q, buf_valid_d;
  logic        buf_branch_q, buf_branch_d;  // buffered redirect is a branch
  logic [31:0] buf_target_q, buf_target_d;

  logic [31:0] br_tgt_s, jp_tgt_s, seq_pc_s, sel_next_s, pc_next_s;
  logic        in_fetch_s, advance_s, pc_en_s, iren_s;

`ifdef FETCH_PERF_EN
  logic [31:0] fetch_count_q, fetch_count_d;
  logic [31:0] redir_count_q, redir_count_d;
`endif

  // Output selection, advance decision and next-state computation
  always_comb begin
    br_tgt_s   = {branch_target[31:2], 2'b00};
    jp_tgt_s   = {jump_target[31:2], 2'b00};
    seq_pc_s   = pc_cur + PC_STEP;
    in_fetch_s = (state_q == S_FETCH);
    advance_s  = in_fetch_s & ihit & ~stall & ~halt;

    // The older branch beats the younger jump. Any live redirect beats the buffer.
    if (branch_take) begin
      sel_next_s = br_tgt_s;
    end else if (jump_take) begin
      sel_next_s = jp_tgt_s;
    end else if (buf_valid_q) begin
      sel_next_s = buf_target_q;
    end else begin
      sel_next_s = seq_pc_s;
    end

    if (!nRST) begin
      pc_en_s   = 1'b0;
      iren_s    = 1'b0;
      pc_next_s = PC_INIT;
    end else if (in_fetch_s) begin
      pc_en_s   = advance_s;
      iren_s    = 1'b1;
      pc_next_s = sel_next_s;
    end else begin
      pc_en_s   = 1'b0;
      iren_s    = 1'b0;
      pc_next_s = pc_cur;
    end

    state_d      = state_q;
    buf_valid_d  = buf_valid_q;
    buf_branch_d = buf_branch_q;
    buf_target_d = buf_target_q;
    case (state_q)
      S_FETCH: begin
        if (halt) begin
          state_d     = S_HALT;
          buf_valid_d = 1'b0;
        end else if (advance_s) begin
          // A redirect that is live in this cycle was already used through pc_next.
          buf_valid_d = 1'b0;
        end else if (branch_take) begin
          // A buffered branch means every later redirect is on the wrong path.
          if (!buf_valid_q || !buf_branch_q) begin
            buf_valid_d  = 1'b1;
            buf_branch_d = 1'b1;
            buf_target_d = br_tgt_s;
          end else begin
            buf_valid_d = buf_valid_q;
          end
        end else if (jump_take) begin
          if (!buf_valid_q) begin
            buf_valid_d  = 1'b1;
            buf_branch_d = 1'b0;
            buf_target_d = jp_tgt_s;
          end else begin
            buf_valid_d = buf_valid_q;
          end
        end else begin
          buf_valid_d = buf_valid_q;
        end
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d     = S_FETCH;
        buf_valid_d = 1'b0;
      end
    endcase

`ifdef FETCH_PERF_EN
    fetch_count_d = fetch_count_q;
    redir_count_d = redir_count_q;
    if (pc_en_s) begin
      fetch_count_d = fetch_count_q + 32'd1;
      if (branch_take || jump_take || buf_valid_q) begin
        redir_count_d = redir_count_q + 32'd1;
      end else begin
        redir_count_d = redir_count_q;
      end
    end else begin
      fetch_count_d = fetch_count_q;
    end
`endif
  end

  // State register with synchronous active-low reset
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q      <= S_FETCH;
      buf_valid_q  <= 1'b0;
      buf_branch_q <= 1'b0;
      buf_target_q <= 32'h0000_0000;
`ifdef FETCH_PERF_EN
      fetch_count_q <= 32'd0;
      redir_count_q <= 32'd0;
`endif
    end else begin
      state_q      <= state_d;
      buf_valid_q  <= buf_valid_d;
      buf_branch_q <= buf_branch_d;
      buf_target_q <= buf_target_d;
`ifdef FETCH_PERF_EN
      fetch_count_q <= fetch_count_d;
      redir_count_q <= redir_count_d;
`endif
    end
  end

  assign pc_EN         = pc_en_s;
  assign iREN          = iren_s;
  assign pc_next       = pc_next_s;
  assign iaddr         = pc_cur;
  assign redir_pending = buf_valid_q;
  assign halted        = (state_q == S_HALT);
`ifdef FETCH_PERF_EN
  assign fetch_count   = fetch_count_q;
  assign redir_count   = redir_count_q;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// ---------------------------------------------------------------------------
// tb_fetch_sequencer
//   Scoreboard bench. Each stimulus row pushes its expected
//   {pc_EN, iREN, pc_next, iaddr, redir_pending, halted} into a queue when it
//   is driven. The value is popped and compared once the DUT settles.
// ---------------------------------------------------------------------------
module tb_fetch_sequencer;

  logic        CLK = 1'b0;
  logic        nRST;
  logic [31:0] pc_cur;
  logic        ihit, stall, branch_take, jump_take, halt;
  logic [31:0] branch_target, jump_target;
  logic        pc_EN, iREN, redir_pending, halted;
  logic [31:0] pc_next, iaddr;
`ifdef FETCH_PERF_EN
  logic [31:0] fetch_count, redir_count;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic        nrst;
    logic [31:0] pc;
    logic        ihit;
    logic        stall;
    logic        bt;
    logic [31:0] btgt;
    logic        jt;
    logic [31:0] jtgt;
    logic        halt;
    logic        en;
    logic        iren;
    logic [31:0] nxt;
    logic        pend;
    logic        hlt;
  } row_t;

  typedef struct packed {
    logic        en;
    logic        iren;
    logic [31:0] nxt;
    logic [31:0] addr;
    logic        pend;
    logic        hlt;
  } exp_t;

  exp_t exp_q[$];

  fetch_sequencer dut (
    .CLK(CLK), .nRST(nRST), .pc_cur(pc_cur), .ihit(ihit), .stall(stall),
    .branch_take(branch_take), .branch_target(branch_target),
    .jump_take(jump_take), .jump_target(jump_target), .halt(halt),
    .pc_EN(pc_EN), .pc_next(pc_next), .iREN(iREN), .iaddr(iaddr),
    .redir_pending(redir_pending), .halted(halted)
`ifdef FETCH_PERF_EN
    , .fetch_count(fetch_count), .redir_count(redir_count)
`endif
  );

  always #5 CLK = ~CLK;

  function automatic row_t mk(input logic nr, input logic [31:0] pc, input logic ih,
                              input logic st, input logic bt, input logic [31:0] btg,
                              input logic jt, input logic [31:0] jtg, input logic hl,
                              input logic en, input logic ir, input logic [31:0] nx,
                              input logic pd, input logic hd);
    row_t r;
    r = '{nrst: nr, pc: pc, ihit: ih, stall: st, bt: bt, btgt: btg, jt: jt,
          jtgt: jtg, halt: hl, en: en, iren: ir, nxt: nx, pend: pd, hlt: hd};
    return r;
  endfunction

  // Drives one row and pushes its expectation into the scoreboard.
  task automatic drive(input row_t r);
    nRST = r.nrst; pc_cur = r.pc; ihit = r.ihit; stall = r.stall;
    branch_take = r.bt; branch_target = r.btgt;
    jump_take = r.jt; jump_target = r.jtgt; halt = r.halt;
    exp_q.push_back('{en: r.en, iren: r.iren, nxt: r.nxt, addr: r.pc,
                      pend: r.pend, hlt: r.hlt});
  endtask

  function automatic exp_t observe();
    exp_t o;
    o = '{en: pc_EN, iren: iREN, nxt: pc_next, addr: iaddr,
          pend: redir_pending, hlt: halted};
    return o;
  endfunction

  task automatic test_reset;
    row_t r[$];
    exp_t g, e;
    r.push_back(mk(1'b0, 32'h100, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0));
    r.push_back(mk(1'b0, 32'h100, 1'b0, 1'b0, 1'b1, 32'h2000, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0));
    foreach (r[i]) begin
      @(negedge CLK); drive(r[i]); #1;
      g = observe(); e = exp_q.pop_front(); n_cmp++;
      if (g !== e) begin n_bad++; $display("FAIL reset[%0d]: got %h want %h", i, g, e); end
    end
  endtask

  task automatic test_sequential;
    row_t r[$];
    exp_t g, e;
    r.push_back(mk(1'b1, 32'h100, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h104, 1'b0, 1'b0));
    r.push_back(mk(1'b1, 32'h104, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h108, 1'b0, 1'b0));
    r.push_back(mk(1'b1, 32'h104, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h108, 1'b0, 1'b0));
    r.push_back(mk(1'b1, 32'h108, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h10C, 1'b0, 1'b0));
    foreach (r[i]) begin
      @(negedge CLK); drive(r[i]); #1;
      g = observe(); e = exp_q.pop_front(); n_cmp++;
      if (g !== e) begin n_bad++; $display("FAIL seq[%0d]: got %h want %h", i, g, e); end
    end
  endtask

  task automatic test_branch_buffer;
    row_t r[$];
    exp_t g, e;
    r.push_back(mk(1'b1, 32'h10C, 1'b0, 1'b0, 1'b1, 32'h2000, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h2000, 1'b0, 1'b0));
    r.push_back(mk(1'b1, 32'h10C, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h2000, 1'b1, 1'b0));
    r.push_back(mk(1'b1, 32'h10C, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h2000, 1'b1, 1'b0));
    r.push_back(mk(1'b1, 32'h10C, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h2000, 1'b1, 1'b0));
    r.push_back(mk(1'b1, 32'h2000, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h2004, 1'b0, 1'b0));
    foreach (r[i]) begin
      @(negedge CLK); drive(r[i]); #1;
      g = observe(); e = exp_q.pop_front(); n_cmp++;
      if (g !== e) begin n_bad++; $display("FAIL branch_buf[%0d]: got %h want %h", i, g, e); end
    end
  endtask

  task automatic test_overwrite;
    row_t r[$];
    exp_t g, e;
    r.push_back(mk(1'b1, 32'h2000, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h300, 1'b0, 1'b0, 1'b1, 32'h300, 1'b0, 1'b0));
    r.push_back(mk(1'b1, 32'h2000, 1'b1, 1'b1, 1'b1, 32'h401, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h400, 1'b1, 1'b0));
    r.push_back(mk(1'b1, 32'h2000, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h500, 1'b0, 1'b0, 1'b1, 32'h500, 1'b1, 1'b0));
    r.push_back(mk(1'b1, 32'h2000, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h400, 1'b1, 1'b0));
    r.push_back(mk(1'b1, 32'h2000, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h400, 1'b1, 1'b0));
    r.push_back(mk(1'b1, 32'h400, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h404, 1'b0, 1'b0));
    foreach (r[i]) begin
      @(negedge CLK); drive(r[i]); #1;
      g = observe(); e = exp_q.pop_front(); n_cmp++;
      if (g !== e) begin n_bad++; $display("FAIL overwrite[%0d]: got %h want %h", i, g, e); end
    end
  endtask

  task automatic test_simultaneous;
    row_t r[$];
    exp_t g, e;
    r.push_back(mk(1'b1, 32'h400, 1'b1, 1'b0, 1'b1, 32'h10, 1'b1, 32'h20, 1'b0, 1'b1, 1'b1, 32'h10, 1'b0, 1'b0));
    r.push_back(mk(1'b1, 32'h10, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h14, 1'b0, 1'b0));
    r.push_back(mk(1'b1, 32'h10, 1'b1, 1'b1, 1'b1, 32'h10, 1'b1, 32'h22, 1'b0, 1'b0, 1'b1, 32'h10, 1'b0, 1'b0));
    r.push_back(mk(1'b1, 32'h10, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h33, 1'b0, 1'b0, 1'b1, 32'h30, 1'b1, 1'b0));
    r.push_back(mk(1'b1, 32'h10, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h10, 1'b1, 1'b0));
    r.push_back(mk(1'b1, 32'h10, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h14, 1'b0, 1'b0));
    foreach (r[i]) begin
      @(negedge CLK); drive(r[i]); #1;
      g = observe(); e = exp_q.pop_front(); n_cmp++;
      if (g !== e) begin n_bad++; $display("FAIL simultaneous[%0d]: got %h want %h", i, g, e); end
    end
  endtask

  task automatic test_wrap;
    row_t r[$];
    exp_t g, e;
    r.push_back(mk(1'b1, 32'hFFFF_FFF8, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0));
    r.push_back(mk(1'b1, 32'hFFFF_FFFC, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h0, 1'b0, 1'b0));
    foreach (r[i]) begin
      @(negedge CLK); drive(r[i]); #1;
      g = observe(); e = exp_q.pop_front(); n_cmp++;
      if (g !== e) begin n_bad++; $display("FAIL wrap[%0d]: got %h want %h", i, g, e); end
    end
  endtask

  task automatic test_reset_midwait;
    row_t r[$];
    exp_t g, e;
    r.push_back(mk(1'b1, 32'h800, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h900, 1'b0, 1'b0, 1'b1, 32'h900, 1'b0, 1'b0));
    r.push_back(mk(1'b1, 32'h800, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h900, 1'b1, 1'b0));
    r.push_back(mk(1'b0, 32'h800, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0));
    r.push_back(mk(1'b1, 32'h800, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h804, 1'b0, 1'b0));
    foreach (r[i]) begin
      @(negedge CLK); drive(r[i]); #1;
      g = observe(); e = exp_q.pop_front(); n_cmp++;
      if (g !== e) begin n_bad++; $display("FAIL reset_midwait[%0d]: got %h want %h", i, g, e); end
    end
  endtask

  // Five PC loads, two of them from redirects (one live, one buffered).
  task automatic test_perf_advances;
    row_t r[$];
    exp_t g, e;
    r.push_back(mk(1'b1, 32'h804, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h808, 1'b0, 1'b0));
    r.push_back(mk(1'b1, 32'h808, 1'b1, 1'b0, 1'b1, 32'hA00, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'hA00, 1'b0, 1'b0));
    r.push_back(mk(1'b1, 32'hA00, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'hB00, 1'b0, 1'b0, 1'b1, 32'hB00, 1'b0, 1'b0));
    r.push_back(mk(1'b1, 32'hA00, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'hB00, 1'b1, 1'b0));
    r.push_back(mk(1'b1, 32'hB00, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'hB04, 1'b0, 1'b0));
    r.push_back(mk(1'b1, 32'hB04, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'hB08, 1'b0, 1'b0));
    foreach (r[i]) begin
      @(negedge CLK); drive(r[i]); #1;
      g = observe(); e = exp_q.pop_front(); n_cmp++;
      if (g !== e) begin n_bad++; $display("FAIL advances[%0d]: got %h want %h", i, g, e); end
    end
`ifdef FETCH_PERF_EN
    @(negedge CLK); ihit = 1'b0; #1;
    n_cmp++;
    if (fetch_count !== 32'd5) begin n_bad++; $display("FAIL fetch_count: got %0d want 5", fetch_count); end
    n_cmp++;
    if (redir_count !== 32'd2) begin n_bad++; $display("FAIL redir_count: got %0d want 2", redir_count); end
`endif
  endtask

  task automatic test_halt;
    row_t r[$];
    exp_t g, e;
    r.push_back(mk(1'b1, 32'hC00, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 32'hC04, 1'b0, 1'b0));
    r.push_back(mk(1'b1, 32'hC00, 1'b1, 1'b0, 1'b1, 32'hD00, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'hC00, 1'b0, 1'b1));
    r.push_back(mk(1'b1, 32'hC00, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'hE00, 1'b0, 1'b0, 1'b0, 32'hC00, 1'b0, 1'b1));
    r.push_back(mk(1'b1, 32'hC40, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'hC40, 1'b0, 1'b1));
    foreach (r[i]) begin
      @(negedge CLK); drive(r[i]); #1;
      g = observe(); e = exp_q.pop_front(); n_cmp++;
      if (g !== e) begin n_bad++; $display("FAIL halt[%0d]: got %h want %h", i, g, e); end
    end
`ifdef FETCH_PERF_EN
    n_cmp++;
    if (fetch_count !== 32'd5 || redir_count !== 32'd2) begin
      n_bad++;
      $display("FAIL perf_freeze: got %0d/%0d want 5/2", fetch_count, redir_count);
    end
`endif
  endtask

  initial begin
    nRST = 1'b0; pc_cur = 32'h0; ihit = 1'b0; stall = 1'b0;
    branch_take = 1'b0; branch_target = 32'h0;
    jump_take = 1'b0; jump_target = 32'h0; halt = 1'b0;
    repeat (2) @(posedge CLK);
    test_reset;
    test_sequential;
    test_branch_buffer;
    test_overwrite;
    test_simultaneous;
    test_wrap;
    test_reset_midwait;
    test_perf_advances;
    test_halt;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
